vector_cmd_sequencer: RTL and testbench
=======================================

// Module: vector_cmd_sequencer
// PURPOSE
// Executes the 4-bit command issued by the UART input interface once vectors A/B are in BRAM.
// Streams A/B element pairs out of the two BRAMs through a credit-controlled output FIFO
// to the arithmetic datapath / UART transmitter; returns a one-cycle done to the input interface.
// Owns the BRAM read ports; the input interface owns the write ports.
// PARAMETERS
// NBytes  1024  elements per vector; elements 0..NBytes-1
// ADDR_W  10    BRAM address width; NBytes <= 2**ADDR_W
// RD_LAT  2     BRAM read latency, cycles from bram_en to valid bram_*_data (>=1)
// FIFO_D  4     output FIFO depth; must be >= RD_LAT+1
// PORTS
// clk          in   1       clock
// reset        in   1       synchronous, active-high reset
// cmd          in   4       command; non-zero for one cycle when issued; 0 = no command
// vec_ready    in   2       [1] = vector A loaded, [0] = vector B loaded
// bram_en      out  1       read enable, shared by BRAM_A and BRAM_B
// bram_addr    out  ADDR_W  read address
// bram_a_data  in   8       BRAM_A read data
// bram_b_data  in   8       BRAM_B read data
// out_valid    out  1       element pair valid
// out_ready    in   1       consumer accepts pair when out_valid && out_ready
// out_a        out  8       element of A
// out_b        out  8       element of B
// out_last     out  1       marks pair NBytes-1
// op_sel       out  4       latched command code, held while busy
// dp_done      in   1       datapath reduction result ready (one-cycle pulse)
// busy         out  1       command in progress
// done         out  1       one-cycle completion pulse; goes to the input interface
// err          out  1       one-cycle pulse, coincident with done, on a rejected command
// BEHAVIOUR
// Reset values: bram_en=0, bram_addr=0, out_valid=0, out_last=0, out_a=out_b=0, op_sel=0,
//   busy=0, done=0, err=0, state=IDLE, FIFO empty, in-flight count=0.
// Command codes:
//   0       no-op, ignored
//   1       vector-B-load echo from the input interface, ignored
//   2  TX_A  stream; requires vec_ready[1]
//   3  TX_B  stream; requires vec_ready[0]
//   4  ADD   stream; requires vec_ready == 2'b11
//   5  SUB   stream; requires vec_ready == 2'b11
//   6  DOT   reduce; requires vec_ready == 2'b11
//   7  MANH  reduce; requires vec_ready == 2'b11
//   8  EUCL  reduce; requires vec_ready == 2'b11
//   9-15    illegal
// FSM states: IDLE, STREAM, DRAIN, WAIT_DP, FINISH.
// IDLE:
//   - cmd sampled at edge k.
//   - Legal and ready: op_sel=cmd, busy=1, state STREAM from k+1.
//   - Illegal, or required vec_ready bit 0: done=err=1 for cycle k+1 only; busy stays 0; op_sel unchanged.
// STREAM:
//   - Read issued (bram_en=1) iff fifo_count + inflight < FIFO_D.
//   - bram_addr starts at 0 and increments by 1 per issued read.
//   - Data from the read issued at cycle t is written to the FIFO at t+RD_LAT.
//   - Earliest out_valid is t+RD_LAT+1.
//   - After the read at address NBytes-1: bram_en=0, state DRAIN. The address never wraps.
// DRAIN: waits for the handshake with out_last=1.
//   - Reduce op (6-8): state WAIT_DP.
//   - Otherwise: state FINISH.
// WAIT_DP: waits for dp_done=1, then state FINISH. dp_done in any other state is ignored.
// FINISH: done=1 for one cycle, busy=0, state IDLE. op_sel holds its value until the next accepted command.
// Output FIFO:
//   - out_* are driven from the FIFO head; out_valid = FIFO not empty.
//   - out_a/out_b hold while out_valid && !out_ready.
//   - Simultaneous FIFO write and pop in one cycle is legal; count is unchanged.
//   - The credit rule guarantees no overflow, so no data is dropped.
// TX_A forces out_b=0; TX_B forces out_a=0.
// Any non-zero cmd while busy=1 is ignored; the running operation is unaffected.
// Reset while busy: all state cleared the next cycle, in-flight read data discarded, no done pulse.
// Throughput: with out_ready held at 1, one pair per cycle in steady state.
// TESTING
// NBytes=8, RD_LAT=2, A=1..8, B=8..1, vec_ready=11, cmd=2, out_ready=1
//   -> 8 pairs, out_a=1..8, out_b=0, last on 8th pair, done 1 cycle after it.
// cmd=6, out_ready toggled 1010...
//   -> pairs (1,8)..(8,1) in order, none lost or duplicated.
//   -> done not asserted until dp_done is pulsed 5 cycles after out_last handshake;
//      done is asserted the cycle after dp_done.
// vec_ready=10, cmd=4 -> done=err=1 on next cycle; busy=0; no bram_en.
// cmd=12 -> done=err=1 on next cycle; busy=0; no bram_en.
// cmd=1 -> no response.
// out_ready=0 for 20 cycles during STREAM -> at most FIFO_D reads outstanding, bram_en stalls;
//   release -> remaining pairs contiguous and correct.
// reset at 4th pair of cmd=3 -> all outputs at reset values next cycle.
//   cmd=3 reissued -> full clean 8-pair stream, done once.

Source files
------------

// File: rtl/vector_cmd_sequencer.sv
// vector_cmd_sequencer: runs one vector command against the two operand BRAMs.
// Reads A/B element pairs through a credit-limited read pipeline into a small
// output FIFO, waits for the datapath on reduce ops, then pulses done.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  S_IDLE    | waiting for a command; rejects illegal / not-ready commands
//  S_STREAM  | issuing BRAM reads, one per cycle while credits allow
//  S_DRAIN   | all reads issued; waiting for the last pair to be accepted
//  S_WAIT_DP | reduce op; waiting for the datapath result pulse
//  S_FINISH  | one-cycle done pulse, then back to idle
module vector_cmd_sequencer #(
  parameter int NBytes = 1024,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd_i,
  input  logic [1:0]        vec_ready_i,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [7:0]        bram_a_data_i,
  input  logic [7:0]        bram_b_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [7:0]        out_a_o,
  output logic [7:0]        out_b_o,
  output logic              out_last_o,
  output logic [3:0]        op_sel_o,
  input  logic              dp_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = $clog2(FIFO_D + RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBytes - 1);
  localparam logic [CNT_W-1:0]  FIFO_D_C  = CNT_W'(FIFO_D);
  localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(FIFO_D - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_DRAIN, S_WAIT_DP, S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        op_sel_q;
  logic              rej_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0] rd_pipe_q;
  logic [RD_LAT-1:0] last_pipe_q;
  logic [CNT_W-1:0]  inflight_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [7:0]        mem_a_q [FIFO_D];
  logic [7:0]        mem_b_q [FIFO_D];
  logic              mem_l_q [FIFO_D];

  logic cmd_legal, cmd_rdy, accept, reject, is_reduce;
  logic credit_ok, fifo_wr, pop;
  logic [7:0] wr_a, wr_b;

  // Command decode: which codes start work and which vector bits they need.
  always_comb begin
    cmd_legal = 1'b0;
    cmd_rdy   = 1'b0;
    case (cmd_i)
      4'd2: begin cmd_legal = 1'b1; cmd_rdy = vec_ready_i[1]; end
      4'd3: begin cmd_legal = 1'b1; cmd_rdy = vec_ready_i[0]; end
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
        cmd_legal = 1'b1;
        cmd_rdy   = &vec_ready_i;
      end
      default: begin cmd_legal = 1'b0; cmd_rdy = 1'b0; end
    endcase
  end

  assign accept    = (state_q == S_IDLE) && cmd_legal && cmd_rdy;
  // Codes 0 and 1 are silent; everything else that cannot run is rejected.
  assign reject    = (state_q == S_IDLE) && (cmd_i > 4'd1) && !(cmd_legal && cmd_rdy);
  assign is_reduce = (op_sel_q >= 4'd6) && (op_sel_q <= 4'd8);

  // A read is only issued when its data is guaranteed a FIFO slot on arrival.
  assign credit_ok = (fifo_cnt_q + inflight_q) < FIFO_D_C;
  assign fifo_wr   = rd_pipe_q[RD_LAT-1];
  assign pop       = out_valid_o && out_ready_i;

  // Single-vector commands zero the unused lane before it enters the FIFO.
  assign wr_a = (op_sel_q == 4'd3) ? 8'd0 : bram_a_data_i;
  assign wr_b = (op_sel_q == 4'd2) ? 8'd0 : bram_b_data_i;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_STREAM;
      S_STREAM:  if (bram_en_o && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
      S_DRAIN:   if (pop && out_last_o) state_d = is_reduce ? S_WAIT_DP : S_FINISH;
      S_WAIT_DP: if (dp_done_i) state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs; a rejected command reuses the done path via rej_q.
  always_comb begin
    bram_en_o = (state_q == S_STREAM) && credit_ok;
    busy_o    = (state_q == S_STREAM) || (state_q == S_DRAIN) || (state_q == S_WAIT_DP);
    done_o    = (state_q == S_FINISH) || rej_q;
    err_o     = rej_q;
  end

  // Command latch, reject pulse and read address counter (never wraps).
  always_ff @(posedge clk) begin
    if (reset) begin
      op_sel_q <= 4'd0;
      rej_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      rej_q <= reject;
      if (accept) begin
        op_sel_q <= cmd_i;
        addr_q   <= '0;
      end else if (bram_en_o && (addr_q != LAST_ADDR)) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Read pipeline: tracks which cycles carry valid BRAM data and the last flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe_q   <= '0;
      last_pipe_q <= '0;
      inflight_q  <= '0;
    end else begin
      rd_pipe_q[0]   <= bram_en_o;
      last_pipe_q[0] <= bram_en_o && (addr_q == LAST_ADDR);
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_q[i]   <= rd_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
      case ({bram_en_o, fifo_wr})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Output FIFO; storage is cleared on reset so out_a/out_b start at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        mem_a_q[i] <= 8'd0;
        mem_b_q[i] <= 8'd0;
        mem_l_q[i] <= 1'b0;
      end
    end else begin
      if (fifo_wr) begin
        mem_a_q[wr_ptr_q] <= wr_a;
        mem_b_q[wr_ptr_q] <= wr_b;
        mem_l_q[wr_ptr_q] <= last_pipe_q[RD_LAT-1];
        wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({fifo_wr, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign out_valid_o = (fifo_cnt_q != '0);
  assign out_a_o     = mem_a_q[rd_ptr_q];
  assign out_b_o     = mem_b_q[rd_ptr_q];
  assign out_last_o  = out_valid_o && mem_l_q[rd_ptr_q];
  assign bram_addr_o = addr_q;
  assign op_sel_o    = op_sel_q;

endmodule

// File: tb/tb_vector_cmd_sequencer.sv
// Directed bench for vector_cmd_sequencer with a BRAM model and pair scoreboard.
module tb_vector_cmd_sequencer;
  localparam int NB = 8;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    cmd = 4'd0;
  logic [1:0]    vec_ready = 2'b00;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_a_data, bram_b_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_a, out_b;
  logic          out_last;
  logic [3:0]    op_sel;
  logic          dp_done = 1'b0;
  logic          busy, done, err;

  vector_cmd_sequencer #(.NBytes(NB), .ADDR_W(AW), .RD_LAT(RL), .FIFO_D(FD)) dut (
    .clk(clk), .reset(reset), .cmd_i(cmd), .vec_ready_i(vec_ready),
    .bram_en_o(bram_en), .bram_addr_o(bram_addr),
    .bram_a_data_i(bram_a_data), .bram_b_data_i(bram_b_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_a_o(out_a), .out_b_o(out_b), .out_last_o(out_last),
    .op_sel_o(op_sel), .dp_done_i(dp_done),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  // BRAM model: data for the address of cycle t appears in cycle t+2.
  logic [7:0]    mem_a [NB];
  logic [7:0]    mem_b [NB];
  logic [AW-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= bram_addr;
    p2 <= p1;
  end
  assign bram_a_data = mem_a[p2[2:0]];
  assign bram_b_data = mem_b[p2[2:0]];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
  } pair_t;

  pair_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0, done_cnt = 0, err_cnt = 0, en_cnt = 0;
  int first_cyc = 0, last_cyc = 0, done_cyc = 0, last_cnt = 0;
  int run_hs0 = 0;
  bit stall_chk = 1'b0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_a, prev_b;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pops, hold check, event counters, credit bound.
  always @(negedge clk) begin
    pair_t obs, e;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (bram_en) en_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) err_cnt++;
      if (prev_hold) begin
        checks++;
        assert ({out_a, out_b} === {prev_a, prev_b}) else begin
          errors++;
          $error("FAIL hold: got %0d/%0d expected %0d/%0d", out_a, out_b, prev_a, prev_b);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_a = out_a;
      prev_b = out_b;
      if (out_valid && out_ready) begin
        obs = {out_a, out_b, out_last};
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_pair: got a=%0d b=%0d expected none", out_a, out_b);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (obs === e) else begin
            errors++;
            $error("FAIL pair: got a=%0d b=%0d last=%0d expected a=%0d b=%0d last=%0d",
                   obs.a, obs.b, obs.last, e.a, e.b, e.last);
          end
        end
        if (hs_cnt == run_hs0) first_cyc = cyc;
        hs_cnt++;
        if (out_last) begin last_cnt++; last_cyc = cyc; end
      end
      if (stall_chk) begin
        checks++;
        assert (en_cnt - hs_cnt <= FD) else begin
          errors++;
          $error("FAIL outstanding: got %0d expected <= %0d", en_cnt - hs_cnt, FD);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c);
    @(posedge clk); #1 cmd = c;
    @(posedge clk); #1 cmd = 4'd0;
  endtask

  task automatic push_run(input int op);
    pair_t p;
    for (int i = 0; i < NB; i++) begin
      p.a    = (op == 3) ? 8'd0 : 8'(i + 1);
      p.b    = (op == 2) ? 8'd0 : 8'(NB - i);
      p.last = (i == NB - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic wait_done(input int base, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      at_neg();
      if (done_cnt > base) break;
    end
    chk("done_seen", done_cnt > base, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_bram_en"}, bram_en, 0);
    chk({tag, "_bram_addr"}, bram_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_a"}, out_a, 0);
    chk({tag, "_out_b"}, out_b, 0);
    chk({tag, "_op_sel"}, op_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int base, ebase, hs0, en0, lc0, dp_cyc;
    for (int i = 0; i < NB; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(NB - i);
    end

    // Reset values
    repeat (3) @(posedge clk);
    at_neg();
    check_reset_vals("rst");
    @(posedge clk); #1 reset = 1'b0;

    // TX_A with out_ready held high
    vec_ready = 2'b11;
    hs0 = hs_cnt; run_hs0 = hs_cnt; en0 = en_cnt; base = done_cnt; ebase = err_cnt;
    push_run(2);
    issue(4'd2);
    at_neg();
    chk("txa_busy", busy, 1);
    chk("txa_op_sel", op_sel, 2);
    wait_done(base, 100);
    chk("txa_pairs", hs_cnt - hs0, NB);
    chk("txa_done_lat", done_cyc, last_cyc + 1);
    chk("txa_thruput", last_cyc - first_cyc, NB - 1);
    chk("txa_reads", en_cnt - en0, NB);
    chk("txa_q_empty", exp_q.size(), 0);
    chk("txa_no_err", err_cnt, ebase);
    at_neg();
    chk("txa_done_pulse", done, 0);
    chk("txa_idle_busy", busy, 0);

    // DOT with ready toggling, dp_done five cycles after the last handshake
    hs0 = hs_cnt; run_hs0 = hs_cnt; lc0 = last_cnt; base = done_cnt;
    push_run(6);
    issue(4'd6);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1 out_ready = ~out_ready;
      if (last_cnt > lc0) break;
    end
    out_ready = 1'b1;
    chk("dot_last_seen", last_cnt - lc0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("dot_no_early_done", done_cnt, base);
    chk("dot_busy_wait", busy, 1);
    dp_done = 1'b1; dp_cyc = cyc;
    @(posedge clk); #1 dp_done = 1'b0;
    wait_done(base, 20);
    chk("dot_done_lat", done_cyc, dp_cyc + 1);
    chk("dot_pairs", hs_cnt - hs0, NB);
    chk("dot_q_empty", exp_q.size(), 0);

    // ADD without vector B loaded is rejected
    vec_ready = 2'b10;
    en0 = en_cnt; base = done_cnt; ebase = err_cnt;
    issue(4'd4);
    @(negedge clk);
    chk("nrdy_done", done, 1);
    chk("nrdy_err", err, 1);
    chk("nrdy_busy", busy, 0);
    chk("nrdy_op_sel", op_sel, 6);
    repeat (3) at_neg();
    chk("nrdy_no_reads", en_cnt - en0, 0);
    chk("nrdy_done_once", done_cnt - base, 1);
    chk("nrdy_err_once", err_cnt - ebase, 1);

    // Illegal code
    vec_ready = 2'b11;
    en0 = en_cnt; base = done_cnt; ebase = err_cnt;
    issue(4'd12);
    @(negedge clk);
    chk("ill_done", done, 1);
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    repeat (3) at_neg();
    chk("ill_no_reads", en_cnt - en0, 0);
    chk("ill_err_once", err_cnt - ebase, 1);

    // Code 1 gets no response
    en0 = en_cnt; base = done_cnt;
    issue(4'd1);
    repeat (5) at_neg();
    chk("echo_no_done", done_cnt, base);
    chk("echo_no_reads", en_cnt - en0, 0);
    chk("echo_busy", busy, 0);

    // SUB with consumer stalled for 20 cycles
    out_ready = 1'b0;
    hs0 = hs_cnt; en0 = en_cnt; base = done_cnt;
    push_run(5);
    issue(4'd5);
    stall_chk = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("stall_reads", en_cnt - en0, FD);
    chk("stall_no_pairs", hs_cnt - hs0, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_head_a", out_a, 1);
    chk("stall_head_b", out_b, NB);
    run_hs0 = hs_cnt;
    out_ready = 1'b1;
    wait_done(base, 100);
    stall_chk = 1'b0;
    chk("stall_pairs", hs_cnt - hs0, NB);
    chk("stall_contig", last_cyc - first_cyc, NB - 1);
    chk("stall_reads_total", en_cnt - en0, NB);
    chk("stall_q_empty", exp_q.size(), 0);

    // Reset in the middle of a TX_B stream
    hs0 = hs_cnt; run_hs0 = hs_cnt;
    push_run(3);
    issue(4'd3);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (hs_cnt - hs0 >= 4) break;
    end
    chk("mid_pairs", hs_cnt - hs0, 4);
    reset = 1'b1;
    exp_q.delete();
    base = done_cnt;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (4) at_neg();
    chk("midrst_no_done", done_cnt, base);
    chk("midrst_no_valid", out_valid, 0);

    // Clean TX_B rerun
    hs0 = hs_cnt; run_hs0 = hs_cnt;
    push_run(3);
    issue(4'd3);
    wait_done(base, 100);
    chk("txb_pairs", hs_cnt - hs0, NB);
    chk("txb_thruput", last_cyc - first_cyc, NB - 1);
    chk("txb_q_empty", exp_q.size(), 0);
    repeat (3) at_neg();
    chk("txb_done_once", done_cnt - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
